// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - latency-modelling load/store responder over an internal word array
// One request in flight: IDLE accepts, BUSY counts down, RESP holds the response until taken.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            cnt;
  logic                  cap_wr;
  logic [31:0]           cap_addr;
  logic [31:0]           cap_wdata;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  accept;
  logic                  access;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign word_idx = cap_addr[ADDR_WIDTH+1:2];
  // Shift form keeps the range check legal even when no high address bits remain.
  assign addr_err = (cap_addr[1:0] != 2'b00) || ((cap_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)     state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0)   state_nxt = RESP;
      RESP:    if (resp_ready)    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    accept     = (state == IDLE) && req_valid;
    access     = (state == BUSY) && (cnt == 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 4'd0;
      cap_wr     <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= CNT_INIT;
        cap_wr    <= req_wr;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        resp_err   <= addr_err;
        resp_rdata <= (addr_err || cap_wr) ? 32'd0 : mem[word_idx];
      end
    end
  end

  // The array has no reset; a store lands only on the BUSY->RESP edge.
  always_ff @(posedge clk) begin
    if (access && cap_wr && !addr_err) begin
      mem[word_idx] <= cap_wdata;
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU data port. It accepts one load or store request per valid/ready handshake and waits a programmable number of cycles to model memory latency. It then performs the access on an internal word array and returns a response through a second valid/ready handshake. It sits between the CPU's data-address/data-in/write-enable outputs and the backing storage, and gives the multi-cycle CPU variant a realistic, stallable memory.

## Interface

- `ADDR_WIDTH`, default 10: word-index bits; array depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: cycles spent in BUSY per request. Legal range is 1..15; other values are illegal, with no checking.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept a request.
- `req_wr`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: requester takes the response.
- `resp_rdata`  out  32: load data; 0 for stores and for errors.
- `resp_err`  out  1: request was misaligned or out of range.

## Operation

- States: IDLE, BUSY, RESP.
- `req_ready` = (state == IDLE). `resp_valid` = (state == RESP).
- **IDLE**
  - On `req_valid && req_ready`, capture `req_wr`, `req_addr` and `req_wdata`.
  - Load the 4-bit counter with LATENCY-1 and go to BUSY.
- **BUSY**
  - If the counter is not 0, decrement it.
  - If the counter is 0, perform the access and go to RESP.
  - `req_valid` is ignored in this state, and input changes do not affect the captured request.
- **Access rules**, using the captured address A:
  - Misaligned: A[1:0] != 0.
  - Out of range: A[31:ADDR_WIDTH+2] != 0.
  - On either error: no array write; `resp_err`=1, `resp_rdata`=0.
  - Valid store: mem[A[ADDR_WIDTH+1:2]] <= wdata; `resp_err`=0, `resp_rdata`=0.
  - Valid load: `resp_rdata` <= mem[A[ADDR_WIDTH+1:2]]; `resp_err`=0.
- **RESP**
  - `resp_rdata` and `resp_err` are registered and stay stable until the handshake.
  - On `resp_valid && resp_ready`, go to IDLE.
  - `resp_ready` asserted outside RESP has no effect.
- The array is not cleared by reset; its contents after power-up are undefined.
- The array write happens only on the BUSY→RESP edge. A store aborted by reset before that edge never modifies the array.

## Timing

- Reset asserted, asynchronous: state=IDLE, counter=0, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. All captured request fields are cleared to 0.
- Request accepted at edge N:
  - BUSY occupies cycles N..N+LATENCY-1.
  - `resp_valid` rises after edge N+LATENCY.
- Load data is visible in the same cycle that `resp_valid` rises.
- Response handshake at edge M: `req_ready`=1 after edge M. The earliest next acceptance is edge M+1.
- Maximum throughput is one transaction per LATENCY+2 cycles, with `resp_ready` held high.
- A store followed by a load to the same address returns the new data, since transactions are strictly serialized.
- Reset during BUSY or RESP abandons the transaction. No response is issued for it.

## Test plan

- **Store/load round trip** (LATENCY=2): store 0xDEADBEEF to 0x0000_0010, then load 0x10.
  - Each response arrives 2 cycles after acceptance.
  - Load returns `resp_rdata`=0xDEADBEEF with `resp_err`=0.
- **Misaligned access**: store 0x12345678 to 0x12 → `resp_err`=1, `resp_rdata`=0. A following load of 0x10 still returns 0xDEADBEEF.
- **Out of range** (ADDR_WIDTH=10): load 0x0000_1000 → `resp_err`=1 and `resp_rdata`=0.
- **Response backpressure**: hold `resp_ready`=0 for 5 cycles after `resp_valid`.
  - `resp_valid`, `resp_rdata` and `resp_err` stay stable.
  - `req_ready` stays 0.
  - Raising `resp_ready` completes the handshake, and `req_ready`=1 on the next cycle.
- **Request ignored while BUSY**: toggle `req_valid`, `req_addr` and `req_wdata` during BUSY.
  - The response reflects the originally captured request.
  - Exactly one response is produced.
- **Reset mid-write** (LATENCY=4): store 0xA5A5A5A5 to 0x20, then assert `reset` low during BUSY before the counter reaches 0.
  - All outputs go to their reset values immediately.
  - After release, a load of 0x20 returns the prior contents (preloaded 0x11111111), not 0xA5A5A5A5.
